rf_scan_reader: RTL
===================

# rf_scan_reader

Read-side sequencer for the 16-entry register file: on a start pulse it sweeps a contiguous, wrapping address range over the file's combinational read port, registers each word, and streams words to a downstream consumer over a valid/ready handshake. It sits between the register file's `raddr`/`q` port and any block that dumps, checksums or copies RF contents. The write port is untouched. Writes landing during a scan are visible only if they complete before the address is sampled.

## Interface
- `ADDR_BITS`, 7, register-file address width
- `DATA_BITS`, 13, register-file word width
- `DEPTH`, 16, number of implemented entries; legal addresses 0..DEPTH-1
- `clk`  in  1  single clock, all state on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin scan; sampled only in IDLE
- `base`  in  ADDR_BITS  first address of scan
- `count`  in  ADDR_BITS+1  number of words to read
- `abort`  in  1  cancel an active scan
- `raddr`  out  ADDR_BITS  to register-file read address
- `q`  in  DATA_BITS  from register-file read data, combinational from `raddr`
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  DATA_BITS  word read
- `out_addr`  out  ADDR_BITS  address the word came from
- `out_last`  out  1  final beat of scan
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse, scan completed normally
- `err`  out  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, SCAN, DRAIN, DONE. Internal `remaining` counter, ADDR_BITS+1 wide.
- IDLE + `start`:
  - `base` ≥ DEPTH -> stay IDLE, pulse `err`.
  - `count` = 0 -> go to DONE, no beats.
  - Otherwise `raddr` <= `base`, `remaining` <= min(`count`, DEPTH), go to SCAN. `count` > DEPTH saturates to DEPTH, so no address is read twice.
- SCAN, load condition: `!out_valid || out_ready`. On load:
  - `out_data` <= `q`, `out_addr` <= `raddr`, `out_valid` <= 1.
  - `out_last` <= (`remaining` == 1).
  - `remaining` decrements.
  - `raddr` advances: DEPTH-1 wraps to 0, else +1.
  - If `remaining` was 1, go to DRAIN. `raddr` still advances but is ignored.
- SCAN, no load: `raddr` and output registers hold (stall).
- DRAIN: `out_valid && out_ready` -> clear `out_valid`, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- Outside a load, an accepted beat (`out_valid && out_ready`) clears `out_valid`.
- `abort` in SCAN or DRAIN:
  - Next cycle: `out_valid` = 0, state IDLE, no `done`.
  - A beat accepted in the abort cycle counts as delivered.
- `abort` in IDLE or DONE has no effect. `start` outside IDLE is ignored.
- `busy` = state ∈ {SCAN, DRAIN}.

## Timing
- Reset values: `raddr`, `out_data`, `out_addr` = 0; `out_valid`, `out_last`, `busy`, `done`, `err` = 0; state IDLE. `reset` overrides `start`/`abort` in the same cycle. Mid-scan reset drops the in-flight beat, with no `done`.
- `start` sampled at edge T:
  - Cycle T+1: `busy` = 1, `raddr` = `base`.
  - First beat visible in cycle T+2.
- Steady state with `out_ready` held 1: one beat per cycle, no bubbles.
- Scan of N words with no stalls:
  - Beats in cycles T+2..T+N+1; `out_last` on beat N.
  - `done` in cycle T+N+2, with `busy` = 0 in that cycle.
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_addr` and `out_last` hold.
- Read data: `q` is sampled in the cycle `raddr` shows that address, with zero added read latency.
- `err` is asserted in cycle T+1 for a rejected start.
- `count` = 0: `done` in T+1, `busy` never set.

## Test plan
- Preload rf[i] = i+0x100. Start with `base`=3, `count`=4, `out_ready`=1 -> beats at T+2..T+5 with addr 3,4,5,6 and data 0x103..0x106; `out_last` only on addr 6; `done` at T+6.
- Wrap: `base`=14, `count`=5 -> addresses 14,15,0,1,2. `count`=40 -> exactly 16 beats, ending at addr 13 with `out_last`.
- Backpressure: `out_ready` toggles 1,0,0,1,… -> no beat lost or duplicated; outputs held during stalls; beat order matches addresses.
- `count`=0 -> `done` at T+1, no `out_valid`. `base`=16 -> `err` pulse at T+1, stays IDLE.
- `abort` on the third beat of an 8-word scan -> `out_valid`/`busy` = 0 next cycle, no `done`; a new `start` is accepted the following cycle.
- `reset` mid-scan -> every output returns to 0 next cycle; `start` pulses while `busy` = 1 are ignored.

Source files
------------

// File: rtl/rf_scan_reader.sv
// rf_scan_reader
//   Read-side sequencer for the register file. A start pulse sweeps a
//   contiguous, wrapping address range over the file's combinational read
//   port. Each word is registered and then streamed to a consumer over a
//   valid/ready handshake.
// Ports:
//   clk, reset           : single clock, synchronous active-high reset
//   start, base, count   : scan request (start is sampled only in IDLE)
//   abort                : cancel an active scan (SCAN/DRAIN only)
//   raddr / q            : register-file read address / combinational data
//   out_valid/out_ready  : output handshake
//   out_data/out_addr    : word and the address it came from
//   out_last             : final beat of the scan
//   busy                 : scan in progress (SCAN or DRAIN)
//   done                 : one-cycle pulse, scan completed normally
//   err                  : one-cycle pulse, start rejected (base out of range)
module rf_scan_reader #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 13,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base,
  input  logic [ADDR_BITS:0]   count,
  input  logic                 abort,
  output logic [ADDR_BITS-1:0] raddr,
  input  logic [DATA_BITS-1:0] q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  localparam logic [ADDR_BITS-1:0] DEPTH_A  = ADDR_BITS'(DEPTH);
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   DEPTH_C  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   REM_ONE  = (ADDR_BITS+1)'(1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   raddr_q, raddr_d;
  logic [ADDR_BITS:0]     remaining_q, remaining_d;
  logic [DATA_BITS-1:0]   out_data_q, out_data_d;
  logic [ADDR_BITS-1:0]   out_addr_q, out_addr_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   err_q, err_d;

  logic accept;   // beat handed to the consumer this cycle
  logic load;     // output slot free (or freeing) while scanning
  logic bad_base;
  logic is_last;

  assign accept   = out_valid_q && out_ready;
  assign load     = (state_q == SCAN) && !abort && (!out_valid_q || out_ready);
  assign bad_base = (base >= DEPTH_A);
  assign is_last  = (remaining_q == REM_ONE);

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      raddr_q     <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !bad_base)
          state_d = (count == '0) ? DONE : SCAN;
      end
      SCAN: begin
        if (abort)                state_d = IDLE;
        else if (load && is_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)       state_d = IDLE;
        else if (accept) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / registered outputs
  always_comb begin
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready;
    err_d       = 1'b0;

    if (state_q == IDLE && start) begin
      if (bad_base) begin
        err_d = 1'b1;
      end else if (count != '0) begin
        raddr_d     = base;
        // Saturate so a long count never revisits an address
        remaining_d = (count > DEPTH_C) ? DEPTH_C : count;
      end
    end

    if (load) begin
      out_data_d  = q;
      out_addr_d  = raddr_q;
      out_valid_d = 1'b1;
      out_last_d  = is_last;
      remaining_d = remaining_q - REM_ONE;
      raddr_d     = (raddr_q == ADDR_MAX) ? '0 : raddr_q + ADDR_ONE;
    end

    // Abort drops any un-accepted beat; an accepted one already went out
    if (abort && (state_q == SCAN || state_q == DRAIN))
      out_valid_d = 1'b0;
  end

  // Outputs
  always_comb begin
    raddr     = raddr_q;
    out_data  = out_data_q;
    out_addr  = out_addr_q;
    out_valid = out_valid_q;
    out_last  = out_last_q;
    err       = err_q;
    busy      = (state_q == SCAN) || (state_q == DRAIN);
    done      = (state_q == DONE);
  end

endmodule
